// File: rtl/div_fu_ctrl.sv
// Initiator-side control for the iterative unsigned divider (RV32M DIV/DIVU/REM/REMU).
// Takes one request from the divide reservation station. Signed operands are turned into
// magnitudes before they go to the divider, and the sign of the result is fixed afterwards.
// Divide-by-zero and signed overflow are answered directly, without starting the divider.
// The tagged result goes to the CDB arbiter over a valid/ready handshake.
//
// Ports:
//   inst_clk, rst_n          clock; synchronous active-low reset
//   flush                    kills the op in flight (highest priority)
//   req_valid/req_ready      request handshake; req_op/rs1/rs2/tag/pd are the payload
//   div_start                one-cycle start pulse to the divider
//   div_a/div_b              operand magnitudes, held until div_done
//   div_q/div_r/div_done     divider result, valid only in the div_done cycle
//   resp_valid/resp_ready    result handshake; resp_data/tag/pd are the payload
module div_fu_ctrl #(
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned PREG_W = 6
) (
    input  logic              inst_clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       req_rs1,
    input  logic [31:0]       req_rs2,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [PREG_W-1:0] req_pd,
    output logic              div_start,
    output logic [31:0]       div_a,
    output logic [31:0]       div_b,
    input  logic [31:0]       div_q,
    input  logic [31:0]       div_r,
    input  logic              div_done,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [PREG_W-1:0] resp_pd
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StResp,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    // Keeps req_ready low while reset is asserted and releases it one cycle after.
    logic                ready_en_q;
    logic                is_rem_q, is_rem_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [31:0]         data_q, data_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [PREG_W-1:0]   pd_q, pd_d;

    logic                req_signed;
    logic                rs2_zero;
    logic                req_ovf;
    logic                accept;
    logic [31:0]         special_data;
    logic [31:0]         mag_a;
    logic [31:0]         mag_b;
    logic [31:0]         quo_fixed;
    logic [31:0]         rem_fixed;

    assign req_ready  = (state_q == StIdle) & ready_en_q;
    assign div_start  = (state_q == StLaunch);
    assign resp_valid = (state_q == StResp);
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign resp_data  = data_q;
    assign resp_tag   = tag_q;
    assign resp_pd    = pd_q;

    // op[0]=0 selects the signed variants, op[1]=1 selects remainder.
    assign req_signed = ~req_op[0];
    assign rs2_zero   = (req_rs2 == 32'h0000_0000);
    assign req_ovf    = req_signed & (req_rs1 == 32'h8000_0000) & (req_rs2 == 32'hFFFF_FFFF);
    assign accept     = req_valid & req_ready & ~flush;

    assign special_data = rs2_zero ? (req_op[1] ? req_rs1 : 32'hFFFF_FFFF)
                                   : (req_op[1] ? 32'h0000_0000 : 32'h8000_0000);

    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
    assign mag_a = (req_signed & req_rs1[31]) ? (32'd0 - req_rs1) : req_rs1;
    assign mag_b = (req_signed & req_rs2[31]) ? (32'd0 - req_rs2) : req_rs2;

    assign quo_fixed = neg_quo_q ? (32'd0 - div_q) : div_q;
    assign rem_fixed = neg_rem_q ? (32'd0 - div_r) : div_r;

    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        tag_d     = tag_q;
        pd_d      = pd_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    is_rem_d = req_op[1];
                    tag_d    = req_tag;
                    pd_d     = req_pd;
                    if (rs2_zero || req_ovf) begin
                        // Divider operands are left untouched so div_b never shows 0.
                        data_d  = special_data;
                        state_d = StResp;
                    end else begin
                        a_d       = mag_a;
                        b_d       = mag_b;
                        neg_quo_d = req_signed & (req_rs1[31] ^ req_rs2[31]);
                        neg_rem_d = req_signed & req_rs1[31];
                        state_d   = StLaunch;
                    end
                end
            end
            StLaunch: begin
                // The start pulse still goes out in this cycle; a flush only
                // means the result must be drained and discarded.
                state_d = flush ? StDrain : StWait;
            end
            StWait: begin
                if (flush) begin
                    state_d = div_done ? StIdle : StDrain;
                end else if (div_done) begin
                    data_d  = is_rem_q ? rem_fixed : quo_fixed;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (flush || resp_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (div_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge inst_clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            tag_q      <= '0;
            pd_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            is_rem_q   <= is_rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            a_q        <= a_d;
            b_q        <= b_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
            pd_q       <= pd_d;
        end
    end

endmodule

// File: tb/tb_div_fu_ctrl.sv
// Bench for div_fu_ctrl: a behavioural divider responder plus a transaction-level
// reference model. Every negedge the DUT outputs are compared against the model.
module tb_div_fu_ctrl;
    localparam int TAG_W  = 5;
    localparam int PREG_W = 6;

    logic              inst_clk = 1'b0;
    logic              rst_n, flush, req_valid, resp_ready, div_done;
    logic [1:0]        req_op;
    logic [31:0]       req_rs1, req_rs2, div_q, div_r;
    logic [TAG_W-1:0]  req_tag;
    logic [PREG_W-1:0] req_pd;
    logic              req_ready, div_start, resp_valid;
    logic [31:0]       div_a, div_b, resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic [PREG_W-1:0] resp_pd;

    always #5 inst_clk = ~inst_clk;

    div_fu_ctrl #(.TAG_W(TAG_W), .PREG_W(PREG_W)) dut (
        .inst_clk   (inst_clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_tag    (req_tag),
        .req_pd     (req_pd),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_q      (div_q),
        .div_r      (div_r),
        .div_done   (div_done),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_pd    (resp_pd)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result straight from the RV32M rules.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        bit is_rem;
        bit is_signed;
        int sa;
        int sb;
        is_rem    = op[1];
        is_signed = !op[0];
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'd0 : 32'h8000_0000;
        if (is_signed) begin
            sa = a;
            sb = b;
            return is_rem ? sa % sb : sa / sb;
        end
        return is_rem ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference model: lifecycle of the single transaction the controller may own.
    bit          m_rst, m_en, m_launch, m_wait, m_present, m_orphan, m_accepted;
    logic [31:0] m_exp;
    logic [TAG_W-1:0]  m_tag;
    logic [PREG_W-1:0] m_pd;

    // Divider responder.
    bit          dv_busy = 0;
    int          dv_cnt = 0;
    logic [31:0] dv_a, dv_b;
    int          lat_force = -1;
    bit          stray_en = 0;
    logic        s_start;
    logic [31:0] s_a, s_b;

    task automatic model_update();
        m_accepted = 0;
        if (!rst_n) begin
            m_rst = 1; m_en = 0;
            m_launch = 0; m_wait = 0; m_present = 0; m_orphan = 0;
        end else begin
            m_rst = 0;
            if (m_present) begin
                if (flush || resp_ready) m_present = 0;
            end else if (m_launch) begin
                m_launch = 0;
                if (flush) m_orphan = 1;
                else m_wait = 1;
            end else if (m_wait) begin
                if (flush) begin
                    m_wait = 0;
                    m_orphan = !div_done;
                end else if (div_done) begin
                    m_wait = 0;
                    m_present = 1;
                end
            end else if (m_orphan) begin
                if (div_done) m_orphan = 0;
            end else if (m_en && req_valid && !flush) begin
                m_accepted = 1;
                m_exp = ref_result(req_op, req_rs1, req_rs2);
                m_tag = req_tag;
                m_pd  = req_pd;
                if (is_special(req_op, req_rs1, req_rs2)) m_present = 1;
                else m_launch = 1;
            end
            m_en = 1;
        end
    endtask

    task automatic divider_update();
        if (!rst_n) begin
            dv_busy = 0;
        end else begin
            if (dv_busy) begin
                if (dv_cnt == 0) dv_busy = 0;
                else dv_cnt--;
            end
            if (s_start) begin
                chk("div_b_nonzero", s_b == 32'd0, 1'b0);
                dv_busy = 1;
                dv_a = s_a;
                dv_b = s_b;
                dv_cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 6));
            end
        end
    endtask

    task automatic divider_drive();
        div_done = 0;
        div_q = $urandom;
        div_r = $urandom;
        if (rst_n && dv_busy && dv_cnt == 0) begin
            div_done = 1;
            div_q = (dv_b != 0) ? dv_a / dv_b : 32'd0;
            div_r = (dv_b != 0) ? dv_a % dv_b : 32'd0;
        end else if (rst_n && stray_en && !dv_busy && !div_start &&
                     $urandom_range(0, 11) == 0) begin
            div_done = 1;  // stray pulse, must be ignored
        end
    endtask

    task automatic cycle();
        @(negedge inst_clk);
        s_start = div_start;
        s_a = div_a;
        s_b = div_b;
        @(posedge inst_clk);
        model_update();
        divider_update();
        #1;
        divider_drive();
    endtask

    always @(negedge inst_clk) begin
        if (chk_en) begin
            if (m_rst) begin
                chk("reset_ctrl", {req_ready, div_start, resp_valid}, 3'b000);
                chk("reset_resp", {resp_tag, resp_pd, resp_data}, 43'd0);
                chk("reset_opnd", {div_a, div_b}, 64'd0);
            end else begin
                chk("req_ready", req_ready,
                    m_en && !(m_launch || m_wait || m_present || m_orphan));
                chk("div_start", div_start, m_launch);
                chk("resp_valid", resp_valid, m_present);
                if (m_present) begin
                    chk("resp_data", resp_data, m_exp);
                    chk("resp_tag_pd", {resp_tag, resp_pd}, {m_tag, m_pd});
                end
                if (dv_busy) chk("div_operands_held", {div_a, div_b}, {dv_a, dv_b});
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [TAG_W-1:0] tag, input logic [PREG_W-1:0] pd);
        req_valid = 1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_tag = tag; req_pd = pd;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (m_accepted) break;
        end
        chk("accept_within_bound", m_accepted, 1'b1);
        req_valid = 0;
    endtask

    task automatic wait_resp(input string name, input logic [31:0] exp,
                             input logic [TAG_W-1:0] tag, input logic [PREG_W-1:0] pd);
        for (int i = 0; i < 100; i++) begin
            if (resp_valid === 1'b1) break;
            cycle();
        end
        chk({name, "_valid"}, resp_valid, 1'b1);
        if (resp_valid === 1'b1) begin
            chk(name, resp_data, exp);
            chk({name, "_tag_pd"}, {resp_tag, resp_pd}, {tag, pd});
        end
        cycle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        rst_n = 0; flush = 0; req_valid = 0; resp_ready = 1;
        req_op = 0; req_rs1 = 0; req_rs2 = 0; req_tag = 0; req_pd = 0;
        div_done = 0; div_q = 0; div_r = 0;

        // Pin the reference function with hand-computed values.
        chk("ref_divu", ref_result(2'b01, 32'd100, 32'd7), 32'd14);
        chk("ref_rem_neg", ref_result(2'b10, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
        chk("ref_rem_negdiv", ref_result(2'b10, 32'd20, 32'hFFFF_FFFD), 32'd2);
        chk("ref_div_ovf", ref_result(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        cycle();
        chk_en = 1;
        cycle();
        cycle();
        rst_n = 1;
        cycle();
        chk("ready_after_reset", req_ready, 1'b1);

        send(2'b01, 32'd100, 32'd7, 5'd5, 6'd9);
        wait_resp("divu_100_7", 32'd14, 5'd5, 6'd9);
        send(2'b11, 32'd100, 32'd7, 5'd6, 6'd10);
        wait_resp("remu_100_7", 32'd2, 5'd6, 6'd10);
        send(2'b00, 32'hFFFF_FFEC, 32'd3, 5'd7, 6'd11);
        wait_resp("div_m20_3", 32'hFFFF_FFFA, 5'd7, 6'd11);
        send(2'b10, 32'hFFFF_FFEC, 32'd3, 5'd8, 6'd12);
        wait_resp("rem_m20_3", 32'hFFFF_FFFE, 5'd8, 6'd12);
        send(2'b10, 32'd20, 32'hFFFF_FFFD, 5'd9, 6'd13);
        wait_resp("rem_20_m3", 32'd2, 5'd9, 6'd13);

        send(2'b00, 32'd5, 32'd0, 5'd10, 6'd14);
        chk("div0_latency", resp_valid, 1'b1);
        wait_resp("div_5_0", 32'hFFFF_FFFF, 5'd10, 6'd14);
        send(2'b11, 32'd5, 32'd0, 5'd11, 6'd15);
        chk("remu0_latency", resp_valid, 1'b1);
        wait_resp("remu_5_0", 32'd5, 5'd11, 6'd15);
        send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 6'd16);
        wait_resp("div_ovf", 32'h8000_0000, 5'd12, 6'd16);
        send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 6'd17);
        wait_resp("rem_ovf", 32'd0, 5'd13, 6'd17);
        send(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 6'd18);
        wait_resp("divu_ovf_ops", 32'd0, 5'd14, 6'd18);

        // Flush while the divider is busy: result must be dropped.
        lat_force = 12;
        send(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd3, 6'd4);
        cycle();
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) seen++;
            cycle();
        end
        chk("flush_no_resp", seen, 0);
        chk("ready_after_drain", req_ready, 1'b1);
        lat_force = -1;
        send(2'b01, 32'd9, 32'd3, 5'd15, 6'd19);
        wait_resp("divu_9_3", 32'd3, 5'd15, 6'd19);

        // Back-pressure on the response.
        resp_ready = 0;
        send(2'b01, 32'd50, 32'd5, 5'd16, 6'd20);
        for (int i = 0; i < 100 && resp_valid !== 1'b1; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold_stable", {resp_valid, req_ready, resp_data, resp_tag, resp_pd},
                {1'b1, 1'b0, 32'd10, 5'd16, 6'd20});
        end
        resp_ready = 1;
        cycle();

        // Reset in the middle of a divide.
        lat_force = 10;
        send(2'b01, 32'd1000, 32'd3, 5'd17, 6'd21);
        cycle();
        cycle();
        rst_n = 0;
        cycle();
        chk("rst_mid_ctrl", {req_ready, resp_valid, div_start}, 3'b000);
        chk("rst_mid_opnd", {div_a, div_b}, 64'd0);
        rst_n = 1;
        cycle();
        lat_force = -1;
        send(2'b01, 32'd8, 32'd2, 5'd18, 6'd22);
        wait_resp("divu_8_2", 32'd4, 5'd18, 6'd22);

        // Randomized traffic.
        stray_en = 1;
        for (int i = 0; i < 4000; i++) begin
            req_valid  = ($urandom_range(0, 2) != 0);
            req_op     = 2'($urandom_range(0, 3));
            req_rs1    = pick();
            req_rs2    = pick();
            req_tag    = TAG_W'($urandom);
            req_pd     = PREG_W'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            rst_n      = ($urandom_range(0, 399) != 0);
            cycle();
        end
        req_valid = 0; flush = 0; resp_ready = 1; rst_n = 1;
        for (int i = 0; i < 30; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
